// File: rtl/full_subt.sv
// full_subt: registered ripple-borrow subtractor computing a - b - bin.
// A chain of WIDTH single-bit borrow cells feeds output registers, giving
// a fixed one-cycle latency and one result per cycle when in_valid is held.
module full_subt #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    input  logic             in_valid,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             out_valid
);

    // borrow_chain[gi] is the borrow entering cell gi; the extra top bit is
    // the borrow leaving the MSB cell.
    logic [WIDTH:0]   borrow_chain;
    logic [WIDTH-1:0] diff_d;
    logic             bout_d;

    logic [WIDTH-1:0] diff_q;
    logic             bout_q;
    logic             out_valid_q;

    assign borrow_chain[0] = bin;

    // One full-subtractor cell per bit; borrows ripple from LSB to MSB.
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_cell
        logic a_bit;
        logic b_bit;
        logic bw_in;

        assign a_bit = a[gi];
        assign b_bit = b[gi];
        assign bw_in = borrow_chain[gi];

        assign diff_d[gi]         = a_bit ^ b_bit ^ bw_in;
        assign borrow_chain[gi+1] = (~a_bit & b_bit) | (~(a_bit ^ b_bit) & bw_in);
    end

    assign bout_d = borrow_chain[WIDTH];

    // Result registers: reset wins, otherwise capture on in_valid and hold
    // the last result while idle so garbage on the operands is ignored.
    always_ff @(posedge clk) begin
        if (rst) begin
            diff_q      <= '0;
            bout_q      <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            out_valid_q <= in_valid;
            if (in_valid) begin
                diff_q <= diff_d;
                bout_q <= bout_d;
            end
        end
    end

    assign diff      = diff_q;
    assign bout      = bout_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_full_subt.sv
// tb_full_subt: exercises a 1-bit and an 8-bit full_subt instance side by
// side. Expected results are queued when operands are driven and popped
// when the matching out_valid appears.
module tb_full_subt;

    logic       clk;
    logic       rst;

    logic       a1, b1, bin1, v1;
    logic       diff1, bout1, ov1;

    logic [7:0] a8, b8;
    logic       bin8, v8;
    logic [7:0] diff8;
    logic       bout8, ov8;

    int total;
    int bad;

    logic [1:0] q1[$];   // {bout, diff}
    logic [8:0] q8[$];   // {bout, diff}
    logic       exp_v8;

    full_subt #(.WIDTH(1)) u_dut1 (
        .clk(clk), .rst(rst), .a(a1), .b(b1), .bin(bin1), .in_valid(v1),
        .diff(diff1), .bout(bout1), .out_valid(ov1)
    );

    full_subt #(.WIDTH(8)) u_dut8 (
        .clk(clk), .rst(rst), .a(a8), .b(b8), .bin(bin8), .in_valid(v8),
        .diff(diff8), .bout(bout8), .out_valid(ov8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Drive the 8-bit instance and queue its reference result.
    task automatic drive8(input logic v, input logic [7:0] aa, input logic [7:0] bb,
                          input logic bi, input logic r);
        logic [8:0] t;
        @(negedge clk);
        rst  = r;
        v8   = v;
        a8   = aa;
        b8   = bb;
        bin8 = bi;
        exp_v8 = v & ~r;
        if (v && !r) begin
            t = {1'b0, aa} - {1'b0, bb} - {8'd0, bi};
            q8.push_back(t);
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1;
        v1 = 1'b1; a1 = 1'b1; b1 = 1'b0; bin1 = 1'b0;
        v8 = 1'b1; a8 = 8'd1; b8 = 8'd0; bin8 = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            total++;
            if ({diff1, bout1, ov1} !== 3'b000) begin
                bad++;
                $display("FAIL reset_w1 cyc%0d: got diff=%b bout=%b ov=%b want 0 0 0", i, diff1, bout1, ov1);
            end
            total++;
            if ({diff8, bout8, ov8} !== 10'd0) begin
                bad++;
                $display("FAIL reset_w8 cyc%0d: got diff=%h bout=%b ov=%b want 00 0 0", i, diff8, bout8, ov8);
            end
        end
        @(negedge clk);
        rst = 1'b0; v1 = 1'b0; v8 = 1'b0;
        $display("reset: held 2 cycles with in_valid=1");
    endtask

    task automatic test_truth_table();
        logic [15:0] tt;
        logic [1:0]  ent;
        logic [1:0]  exp;
        tt = 16'b00_11_11_01_10_00_00_11;   // {diff,bout} for abc=000..111
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            v1 = 1'b1;
            {a1, b1, bin1} = 3'(i);
            ent = tt[15 - 2*i -: 2];
            q1.push_back({ent[0], ent[1]});
            @(posedge clk); #1;
            total++;
            if (ov1 !== 1'b1 || q1.size() == 0) begin
                bad++;
                $display("FAIL truth_valid abc=%03b: got ov=%b want 1", 3'(i), ov1);
                if (q1.size() != 0) void'(q1.pop_front());
            end else begin
                exp = q1.pop_front();
                if ({bout1, diff1} !== exp) begin
                    bad++;
                    $display("FAIL truth abc=%03b: got diff=%b bout=%b want diff=%b bout=%b",
                             3'(i), diff1, bout1, exp[0], exp[1]);
                end
            end
            $display("truth abc=%03b -> diff=%b bout=%b ov=%b", 3'(i), diff1, bout1, ov1);
        end
        @(negedge clk);
        v1 = 1'b0;
    endtask

    task automatic test_hold();
        @(negedge clk);
        v1 = 1'b1; a1 = 1'b1; b1 = 1'b0; bin1 = 1'b0;
        @(posedge clk); #1;
        total++;
        if ({ov1, diff1, bout1} !== 3'b110) begin
            bad++;
            $display("FAIL hold_accept: got ov=%b diff=%b bout=%b want 1 1 0", ov1, diff1, bout1);
        end
        @(negedge clk);
        v1 = 1'b0; a1 = 1'b0; b1 = 1'b1; bin1 = 1'b1;
        @(posedge clk); #1;
        total++;
        if ({ov1, diff1, bout1} !== 3'b010) begin
            bad++;
            $display("FAIL hold_changed: got ov=%b diff=%b bout=%b want 0 1 0", ov1, diff1, bout1);
        end
        @(negedge clk);
        a1 = 1'bx; b1 = 1'bz; bin1 = 1'bx;
        @(posedge clk); #1;
        total++;
        if ({ov1, diff1, bout1} !== 3'b010) begin
            bad++;
            $display("FAIL hold_xz: got ov=%b diff=%b bout=%b want 0 1 0", ov1, diff1, bout1);
        end
        $display("hold: diff=%b bout=%b ov=%b after idle with changed/X inputs", diff1, bout1, ov1);
        a1 = 1'b0; b1 = 1'b0; bin1 = 1'b0;
    endtask

    task automatic test_arith8();
        logic [7:0] ta[3];
        logic [7:0] tb[3];
        logic       tc[3];
        logic [8:0] want[3];
        logic [8:0] exp;
        ta = '{8'h50, 8'h00, 8'h3C};
        tb = '{8'h20, 8'hFF, 8'h3C};
        tc = '{1'b1,  1'b1,  1'b1};
        want = '{{1'b0, 8'h2F}, {1'b1, 8'h00}, {1'b1, 8'hFF}};
        for (int i = 0; i < 3; i++) begin
            drive8(1'b1, ta[i], tb[i], tc[i], 1'b0);
            @(posedge clk); #1;
            total++;
            if (ov8 !== 1'b1 || q8.size() == 0) begin
                bad++;
                $display("FAIL arith8_valid #%0d: got ov=%b want 1", i, ov8);
                if (q8.size() != 0) void'(q8.pop_front());
            end else begin
                exp = q8.pop_front();
                if ({bout8, diff8} !== exp || exp !== want[i]) begin
                    bad++;
                    $display("FAIL arith8 #%0d: got diff=%h bout=%b want diff=%h bout=%b",
                             i, diff8, bout8, want[i][7:0], want[i][8]);
                end
            end
            $display("arith8 %h-%h-%b -> diff=%h bout=%b", ta[i], tb[i], tc[i], diff8, bout8);
        end
        drive8(1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
        @(posedge clk); #1;
    endtask

    task automatic test_midstream_reset();
        logic [8:0] exp;
        for (int i = 0; i < 3; i++) begin
            drive8(1'b1, 8'(8'h90 + i), 8'(8'h11 * (i + 1)), 1'b0, (i == 1));
            @(posedge clk); #1;
            total++;
            if (ov8 !== exp_v8) begin
                bad++;
                $display("FAIL midrst_valid #%0d: got ov=%b want %b", i, ov8, exp_v8);
            end
            if (i == 1) begin
                total++;
                if ({bout8, diff8} !== 9'd0) begin
                    bad++;
                    $display("FAIL midrst_cleared: got diff=%h bout=%b want 00 0", diff8, bout8);
                end
            end else if (q8.size() == 0) begin
                bad++;
                $display("FAIL midrst_queue #%0d: no expected result queued", i);
            end else begin
                exp = q8.pop_front();
                total++;
                if ({bout8, diff8} !== exp) begin
                    bad++;
                    $display("FAIL midrst_data #%0d: got diff=%h bout=%b want diff=%h bout=%b",
                             i, diff8, bout8, exp[7:0], exp[8]);
                end
            end
            $display("midrst #%0d rst=%0d -> diff=%h bout=%b ov=%b", i, (i == 1), diff8, bout8, ov8);
        end
        drive8(1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
        @(posedge clk); #1;
    endtask

    task automatic test_random8();
        int accepted;
        int seen;
        int errs;
        logic [8:0] exp;
        accepted = 0;
        seen = 0;
        errs = 0;
        for (int i = 0; i < 1000; i++) begin
            drive8(($urandom_range(0, 3) != 0), 8'($urandom), 8'($urandom), 1'($urandom), 1'b0);
            if (exp_v8) accepted++;
            @(posedge clk); #1;
            if (ov8 === 1'b1) seen++;
            total++;
            if (ov8 !== exp_v8) begin
                bad++;
                errs++;
                $display("FAIL rand_valid #%0d: got ov=%b want %b", i, ov8, exp_v8);
            end
            if (ov8 === 1'b1 && q8.size() != 0) begin
                exp = q8.pop_front();
                total++;
                if ({bout8, diff8} !== exp) begin
                    bad++;
                    errs++;
                    $display("FAIL rand_data #%0d: a=%h b=%h bin=%b got diff=%h bout=%b want diff=%h bout=%b",
                             i, a8, b8, bin8, diff8, bout8, exp[7:0], exp[8]);
                end
            end
        end
        drive8(1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
        @(posedge clk); #1;
        total++;
        if (seen != accepted || q8.size() != 0) begin
            bad++;
            $display("FAIL rand_count: got %0d results (%0d left queued) want %0d",
                     seen, q8.size(), accepted);
        end
        $display("random: %0d accepted, %0d results, %0d errors", accepted, seen, errs);
    endtask

    initial begin
        total = 0;
        bad = 0;
        rst = 1'b0;
        v1 = 1'b0; a1 = 1'b0; b1 = 1'b0; bin1 = 1'b0;
        v8 = 1'b0; a8 = 8'd0; b8 = 8'd0; bin8 = 1'b0;
        exp_v8 = 1'b0;

        test_reset();
        test_truth_table();
        test_hold();
        test_arith8();
        test_midstream_reset();
        test_random8();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/full_subt.md
Name: full_subt

Overview:
- Registered ripple-borrow subtractor: computes a − b − bin over WIDTH bits and produces a difference and a borrow-out.
- WIDTH=1 (default) is the classic single-bit full subtractor used as the leaf cell in arithmetic datapaths.
- Wider instances chain WIDTH internal single-bit borrow cells. Results are captured in output registers, so it drops into a pipelined datapath with a one-cycle latency.

Parameters:
- WIDTH, 1, operand/difference width in bits (≥1).

Ports:
- clk  input  1  rising-edge clock; all state updates on this edge.
- rst  input  1  synchronous active-high reset.
- a  input  WIDTH  minuend.
- b  input  WIDTH  subtrahend.
- bin  input  1  borrow-in into the LSB cell.
- in_valid  input  1  operands valid this cycle; result is captured only when high.
- diff  output  WIDTH  registered difference.
- bout  output  1  registered borrow-out from the MSB cell.
- out_valid  output  1  high for exactly one cycle per accepted operand set.

Behaviour:
- Per-bit cell i, with borrow b_0 = bin:
  - d_i = a_i ^ b_i ^ b_i_in
  - borrow out = (~a_i & b_i) | (~(a_i ^ b_i) & b_i_in)
  - The borrow out of cell i feeds cell i+1; bout is the borrow out of cell WIDTH−1.
- Arithmetic equivalence: {bout, diff} = (a − b − bin) mod 2^(WIDTH+1). bout=1 iff a < b + bin (unsigned).
- Operands are treated as unsigned. No signed overflow output.
- Reset: on a rising clk with rst=1, diff=0, bout=0, out_valid=0. rst has priority over in_valid.
- Accept: on a rising clk with rst=0 and in_valid=1, diff/bout register the combinational result of the current a, b, bin, and out_valid goes to 1.
- Idle: on a rising clk with rst=0 and in_valid=0, diff/bout hold their last values and out_valid goes to 0.
- Latency: exactly 1 cycle from the in_valid edge to the out_valid/result edge. Throughput: one operation per cycle, back-to-back with no bubbles.
- Outputs are purely registered: no combinational path from any input to diff, bout or out_valid.
- Reset mid-stream: any operation accepted in the same cycle as rst is discarded. The first valid result after rst deasserts comes from the first in_valid cycle after deassertion.
- Boundaries:
  - a=0, b=all-ones, bin=1 → diff=0, bout=1 (full wrap).
  - a=b, bin=0 → diff=0, bout=0.
  - a=b, bin=1 → diff=all-ones, bout=1.
- X/Z on a, b or bin while in_valid=0 must not disturb the held outputs.

Test Plan:
- Reset: hold rst=1 for 2 cycles with in_valid=1 and a=1, b=0 → diff=0, bout=0, out_valid=0 throughout.
- WIDTH=1 exhaustive truth table, 8 back-to-back in_valid cycles over a,b,bin = 000..111 → one cycle later {diff,bout} = 00, 11, 11, 01, 10, 00, 00, 11 in order, with out_valid high for all 8 cycles.
- Hold: after accepting a=1, b=0, bin=0 (diff=1, bout=0), drop in_valid and change the inputs → diff stays 1, bout stays 0, out_valid=0.
- WIDTH=8 arithmetic:
  - a=0x50, b=0x20, bin=1 → diff=0x2F, bout=0.
  - a=0x00, b=0xFF, bin=1 → diff=0x00, bout=1.
  - a=0x3C, b=0x3C, bin=1 → diff=0xFF, bout=1.
- Mid-stream reset: issue in_valid on 3 consecutive cycles with rst asserted during the 2nd → the 2nd result is dropped and out_valid=0 that cycle. The 3rd result appears normally one cycle later.
- Random WIDTH=8: 1000 random a, b, bin with random in_valid → every out_valid result matches (a − b − bin) mod 512 split as {bout, diff}, and the out_valid count equals the accepted-input count.
